// File: rtl/mem_port_if.sv
// mem_port_if: requester, memory and stall signals of the shared memory port arbiter.
interface mem_port_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              if_err;
   logic              lsu_req;
   logic              lsu_we;
   logic [ADDR_W-1:0] lsu_addr;
   logic [DATA_W-1:0] lsu_wdata;
   logic [DATA_W/8-1:0] lsu_bmask;
   logic [DATA_W-1:0] lsu_rdata;
   logic              lsu_ack;
   logic              lsu_err;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W/8-1:0] mem_bmask;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              stall_if;
   logic              stall_lsu;
   modport master (
      input  if_req, if_addr, lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_bmask, mem_rdata, mem_ack,
      output if_rdata, if_ack, if_err, lsu_rdata, lsu_ack, lsu_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_bmask, stall_if, stall_lsu
   );
   modport slave (
      output if_req, if_addr, lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_bmask, mem_rdata, mem_ack,
      input  if_rdata, if_ack, if_err, lsu_rdata, lsu_ack, lsu_err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_bmask, stall_if, stall_lsu
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and LSU with per-transaction timeout.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise LSU wins ties.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input logic        clk,
   input logic        rst,
   mem_port_if.master bus
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] BUSY_IF  = 2'd1;
   localparam logic [1:0] BUSY_LSU = 2'd2;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          pick_lsu, any_req, busy_if, busy_lsu, timeout, done;
   assign any_req = bus.if_req || bus.lsu_req;
`ifdef MEM_ARB_RR_EN
   logic last_lsu;
   assign pick_lsu = bus.lsu_req && (!bus.if_req || !last_lsu);
   always_ff @(posedge clk)
      if (rst) last_lsu <= 1'b0;
      else if (state == IDLE && any_req) last_lsu <= pick_lsu;
`else
   assign pick_lsu = bus.lsu_req;
`endif
   assign busy_if   = state == BUSY_IF;
   assign busy_lsu  = state == BUSY_LSU;
   // mem_ack on the last allowed cycle still counts as a normal completion
   assign timeout   = cnt == CW'(TIMEOUT_CYC - 1) && !bus.mem_ack;
   assign done      = (busy_if || busy_lsu) && (bus.mem_ack || timeout);
   assign bus.if_ack    = busy_if && done;
   assign bus.if_err    = busy_if && timeout;
   assign bus.if_rdata  = busy_if && bus.mem_ack ? bus.mem_rdata : {DATA_W{1'b0}};
   assign bus.lsu_ack   = busy_lsu && done;
   assign bus.lsu_err   = busy_lsu && timeout;
   assign bus.lsu_rdata = busy_lsu && bus.mem_ack ? bus.mem_rdata : {DATA_W{1'b0}};
   assign bus.stall_if  = bus.if_req && !bus.if_ack;
   assign bus.stall_lsu = bus.lsu_req && !bus.lsu_ack;
   always_ff @(posedge clk)
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= {ADDR_W{1'b0}};
         bus.mem_wdata <= {DATA_W{1'b0}};
         bus.mem_bmask <= '0;
      end else if (state == IDLE) begin
         if (any_req) begin
            state         <= pick_lsu ? BUSY_LSU : BUSY_IF;
            cnt           <= '0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= pick_lsu && bus.lsu_we;
            bus.mem_addr  <= pick_lsu ? bus.lsu_addr : bus.if_addr;
            bus.mem_wdata <= pick_lsu ? bus.lsu_wdata : {DATA_W{1'b0}};
            bus.mem_bmask <= pick_lsu ? bus.lsu_bmask : {(DATA_W/8){1'b1}};
         end
      end else if (done) begin
         state       <= IDLE;
         bus.mem_req <= 1'b0;
      end else
         cnt <= cnt + 1'b1;
endmodule
